// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch front end: word width, reset PC,
// buffered fetch entry and fetch sequencer states.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush empties it and
// takes priority over a push or pop in the same cycle.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-limited in-order instruction memory requests, response
// buffering with PC tagging, and redirect flush with discard of in-flight words.
//
//  state  | meaning
//  S_IDLE | one cycle after reset release, no request
//  S_REQ  | imem_req asserted, at least one credit available
//  S_HOLD | no credit left, request withheld
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [WORD_W-1:0] pcq_q [FIFO_DEPTH];
    logic [WORD_W-1:0] pcq_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  pcq_wr_q, pcq_wr_d;
    logic [PTR_W-1:0]  pcq_rd_q, pcq_rd_d;

    logic              grant;
    logic              resp;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  fifo_count_nxt;
    logic [CNT_W-1:0]  credits_nxt;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign grant     = imem_req & imem_gnt;
    // Responses with nothing outstanding (e.g. straight after reset) are ignored.
    assign resp      = imem_rvalid & (inflight_q != '0);
    assign push      = resp & (discard_q == '0) & ~redirect;

    assign instr_valid = ~fifo_empty & ~redirect;
    assign pop         = instr_valid & instr_ready;
    assign instruction = head.instr;
    assign pc_out      = head.pc;

    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = pcq_q[pcq_rd_q];

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        inflight_d = inflight_q + CNT_W'(grant) - CNT_W'(resp);

        discard_d = discard_q;
        if (redirect) begin
            discard_d = inflight_d;
        end else if (resp && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end

        pc_d = pc_q;
        if (redirect) begin
            pc_d = word_align(redirect_pc);
        end else if (grant) begin
            pc_d = pc_q + 32'd4;
        end

        // PC queue entries live exactly as long as their request is in flight,
        // including requests that will be discarded after a redirect.
        pcq_d    = pcq_q;
        pcq_wr_d = pcq_wr_q;
        pcq_rd_d = pcq_rd_q;
        if (grant) begin
            pcq_d[pcq_wr_q] = pc_q;
            pcq_wr_d        = ptr_inc(pcq_wr_q);
        end
        if (resp) begin
            pcq_rd_d = ptr_inc(pcq_rd_q);
        end

        fifo_count_nxt = redirect ? '0 : (fifo_count + CNT_W'(push) - CNT_W'(pop));
        credits_nxt    = DEPTH_C - fifo_count_nxt - inflight_d;
    end

    // Next state is taken from next-cycle credits so a registered imem_req never
    // asks for a word that would have nowhere to land.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = (credits_nxt != '0) ? S_REQ : S_HOLD;
            S_REQ:   if (credits_nxt == '0) state_d = S_HOLD;
            S_HOLD:  if (credits_nxt != '0) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= word_align(RESET_PC);
            inflight_q <= '0;
            discard_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pcq_q[i] <= '0;
            end
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            pcq_q      <= pcq_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: in-order memory model with random
// latency, instruction-stream scoreboard, vector table and corner-case sequences.
module tb_instruction_fetch;
    import mips_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] exp_pc;
    logic [31:0] salt;
    int          pops;
    int          grants;
    int          gnt_pct, rdy_pct, lat_min, lat_max;
    logic        stray;
    logic        prev_pend;
    logic [31:0] prev_addr;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc;

    typedef struct {
        logic        gnt;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;
    vec_t tv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic resp_due_next();
        return (q_addr.size() > 0) && (q_due[0] <= cyc + 1);
    endfunction

    // One clock: drive inputs at the falling edge, sample, score, then let the edge happen.
    task automatic step(input logic rd = 1'b0, input logic [31:0] rpc = 32'h0);
        logic from_mem;
        cyc++;
        from_mem = (q_addr.size() > 0) && (q_due[0] <= cyc);
        if (from_mem) begin
            imem_rvalid = 1'b1;
            imem_rdata  = q_addr[0] ^ salt;
        end else if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        instr_ready = ($urandom_range(99) < rdy_pct);
        redirect    = rd;
        redirect_pc = rd ? rpc : $urandom;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_pc    = pc_out;
        if (prev_pend) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", imem_addr, prev_addr);
        end
        if (rd) chk("valid_in_redirect", 32'(instr_valid), 32'd0);
        if (instr_valid && instr_ready) begin
            chk("stream_pc", pc_out, exp_pc);
            chk("stream_instr", instruction, exp_pc ^ salt);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (rd) exp_pc = {rpc[31:2], 2'b00};
        if (from_mem) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (imem_req && imem_gnt) begin
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            grants++;
        end
        chk("credit_bound", 32'(q_addr.size() <= DEPTH), 32'd1);
        prev_pend = imem_req && !imem_gnt && !rd;
        prev_addr = imem_addr;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_model();
        q_addr.delete();
        q_due.delete();
        exp_pc    = 32'h0;
        prev_pend = 1'b0;
        grants    = 0;
        pops      = 0;
    endtask

    task automatic wait_first_valid(input string name, input logic [31:0] want);
        int n;
        n = 0;
        step();
        while (!s_valid && n < 40) begin
            step();
            n++;
        end
        chk({name, "_seen"}, 32'(s_valid), 32'd1);
        chk(name, s_pc, want);
    endtask

    initial begin
        int n;
        int g0;
        int p0;
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stray       = 1'b0;
        salt        = 32'h0;
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        clear_model();

        tv[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
        tv[1] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tv[2] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        tv[3] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h0};
        tv[4] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        tv[5] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
        tv[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
        tv[7] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
        tv[8] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h0};

        // Reset values
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start-up and streaming vectors, memory latency 1
        for (int i = 0; i < 9; i++) begin
            gnt_pct = tv[i].gnt ? 100 : 0;
            rdy_pct = tv[i].rdy ? 100 : 0;
            step();
            chk($sformatf("tv%0d_req", i), 32'(s_req), 32'(tv[i].req));
            chk($sformatf("tv%0d_addr", i), s_addr, tv[i].addr);
            chk($sformatf("tv%0d_valid", i), 32'(s_valid), 32'(tv[i].valid));
            if (tv[i].valid) chk($sformatf("tv%0d_pc", i), s_pc, tv[i].pc);
        end

        // Backpressure: decode stalls, exactly DEPTH words stay buffered
        gnt_pct = 100; rdy_pct = 0;
        repeat (12) step();
        chk("bp_outstanding", 32'(q_addr.size()), 32'd0);
        chk("bp_req_off", 32'(imem_req), 32'd0);
        chk("bp_buffered", 32'(grants - pops), 32'(DEPTH));
        chk("bp_valid", 32'(instr_valid), 32'd1);
        rdy_pct = 100;
        g0 = grants; p0 = pops;
        repeat (20) step();
        chk("bp_fetch_resumed", 32'(grants > g0 + 5), 32'd1);
        chk("bp_drained", 32'(pops > p0 + 5), 32'd1);

        // Redirect with two requests in flight
        lat_min = 4; lat_max = 4;
        n = 0;
        while (q_addr.size() < 2 && n < 50) begin
            step();
            n++;
        end
        chk("rd4_two_inflight", 32'(q_addr.size()), 32'd2);
        step(1'b1, 32'h40);
        chk("rd4_addr", imem_addr, 32'h40);
        wait_first_valid("rd4_first_pc", 32'h40);

        // Redirect coincident with grant and response, unaligned target
        lat_min = 1; lat_max = 1;
        n = 0;
        while (!(imem_req && resp_due_next()) && n < 40) begin
            step();
            n++;
        end
        chk("rd5a_coincident", 32'(imem_req && resp_due_next()), 32'd1);
        step(1'b1, 32'h43);
        chk("rd5a_addr", imem_addr, 32'h40);
        wait_first_valid("rd5a_first_pc", 32'h40);

        // Second redirect while the first is still discarding
        lat_min = 4; lat_max = 4;
        repeat (6) step();
        n = 0;
        while (q_addr.size() == 0 && n < 40) begin
            step();
            n++;
        end
        step(1'b1, 32'h100);
        step(1'b1, 32'h40);
        chk("rd5b_addr", imem_addr, 32'h40);
        wait_first_valid("rd5b_first_pc", 32'h40);

        // PC wrap from the top of the address space
        lat_min = 1; lat_max = 2;
        step(1'b1, 32'hFFFF_FFF8);
        p0 = pops;
        repeat (20) step();
        chk("wrap_progress", 32'(pops >= p0 + 5), 32'd1);

        // Asynchronous reset mid-stream with the buffer full
        lat_min = 1; lat_max = 1; rdy_pct = 0;
        repeat (10) step();
        chk("pre_rst_full", 32'(instr_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instruction, 32'h0);
        chk("mid_rst_pc_out", pc_out, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        clear_model();
        salt = 32'h1357_9BDF;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        rdy_pct = 100;
        stray   = 1'b1;
        step();
        stray   = 1'b0;
        chk("rst2_idle_req", 32'(s_req), 32'd0);
        step();
        chk("rst2_req", 32'(s_req), 32'd1);
        chk("rst2_addr", s_addr, 32'h0);
        p0 = pops;
        repeat (20) step();
        chk("rst2_progress", 32'(pops >= p0 + 5), 32'd1);

        // Random traffic with occasional redirects
        gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 4;
        p0 = pops;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 3) begin
                step(1'b1, ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 : $urandom);
            end else begin
                step();
            end
        end
        chk("random_progress", 32'(pops > p0 + 200), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
